mlp_vector_sequencer: RTL

MLP_VECTOR_SEQUENCER -- requirements
Module: mlp_vector_sequencer

---
 rtl/mlp_vector_sequencer_if.sv | 31 +++
 rtl/mlp_vector_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/mlp_vector_sequencer_if.sv
// Feature-in / result-out handshake bundle for the MLP sequencer.
// master drives features and takes results; slave is the sequencer.
interface mlp_vector_sequencer_if #(
  parameter int WIDTH_A  = 4,
  parameter int OUTWIDTH = 2
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH_A-1:0]  in_data;
  logic                res_valid;
  logic                res_ready;
  logic [OUTWIDTH-1:0] res_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  res_valid,
    input  res_data,
    output res_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output res_valid,
    output res_data,
    input  res_ready
  );
endinterface

// File: rtl/mlp_vector_sequencer.sv
// Streams features into a vector for a combinational MLP, waits for it
// to settle, then presents the captured class on a result handshake.
module mlp_vector_sequencer #(
  parameter int NUM_A         = 8,
  parameter int WIDTH_A       = 4,
  parameter int OUTWIDTH      = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  mlp_vector_sequencer_if.slave    bus,
  output logic [NUM_A*WIDTH_A-1:0] inp,
  input  logic [OUTWIDTH-1:0]      out,
  output logic [15:0]              vec_count,
  output logic                     busy
);

  localparam int VW = NUM_A * WIDTH_A;
  localparam int IW = (NUM_A > 1) ? $clog2(NUM_A) : 1;

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    RESULT
  } state_t;

  state_t              state, state_n;
  logic [IW-1:0]       idx, idx_n;
  logic [VW-1:0]       shadow, shadow_n;
  logic [VW-1:0]       inp_q, inp_n;
  logic [7:0]          cnt, cnt_n;
  logic                rv, rv_n;
  logic [OUTWIDTH-1:0] rd, rd_n;
  logic [15:0]         vcnt, vcnt_n;
  logic                rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      idx    <= '0;
      shadow <= '0;
      inp_q  <= '0;
      cnt    <= '0;
      rv     <= 1'b0;
      rd     <= '0;
      vcnt   <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      shadow <= shadow_n;
      inp_q  <= inp_n;
      cnt    <= cnt_n;
      rv     <= rv_n;
      rd     <= rd_n;
      vcnt   <= vcnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    shadow_n = shadow;
    inp_n    = inp_q;
    cnt_n    = cnt;
    rv_n     = rv;
    rd_n     = rd;
    vcnt_n   = vcnt;
    rdy      = 1'b0;
    unique case (state)
      LOAD: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          shadow_n[int'(idx)*WIDTH_A +: WIDTH_A] = bus.in_data;
          if (idx == IW'(NUM_A - 1)) begin
            // commit includes the feature landing this very edge
            inp_n   = shadow_n;
            idx_n   = '0;
            cnt_n   = 8'(SETTLE_CYCLES - 1);
            state_n = SETTLE;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      SETTLE: begin
        if (cnt == 8'd0) begin
          rd_n    = out;
          rv_n    = 1'b1;
          state_n = RESULT;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          rv_n    = 1'b0;
          vcnt_n  = vcnt + 16'd1;
          state_n = LOAD;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  assign bus.in_ready  = rdy;
  assign bus.res_valid = rv;
  assign bus.res_data  = rd;
  assign inp           = inp_q;
  assign vec_count     = vcnt;
  assign busy          = (state != LOAD);

endmodule
